// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between two issuing units and the ALU arbiter.
// The arbiter uses the slave modport; a requester-side model uses master.
`timescale 1ns/1ps
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_carry,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_carry,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered onto the ALU, the result captured one cycle later and returned to the owner.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_num_1,
    output logic [WIDTH-1:0] alu_num_2,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   prio;
    logic   owner;
    logic   gnt_sel;
    logic   accept;
    logic   complete;

    always_comb begin
        state_nxt      = state;
        gnt_sel        = prio;
        accept         = 1'b0;
        complete       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        unique case (state)
            IDLE: begin
                // A lone requester wins outright; prio only breaks ties.
                if (bus.req0_valid && !bus.req1_valid)      gnt_sel = 1'b0;
                else if (bus.req1_valid && !bus.req0_valid) gnt_sel = 1'b1;
                accept         = bus.req0_valid || bus.req1_valid;
                bus.req0_ready = accept && !gnt_sel;
                bus.req1_ready = accept && gnt_sel;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                bus.rsp0_valid = !owner;
                bus.rsp1_valid = owner;
                complete       = owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (complete) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            prio           <= 1'b0;
            owner          <= 1'b0;
            alu_num_1      <= '0;
            alu_num_2      <= '0;
            alu_opcode     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_carry  <= 1'b0;
            done0_cnt      <= '0;
            done1_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= gnt_sel;
                alu_num_1  <= gnt_sel ? bus.req1_a  : bus.req0_a;
                alu_num_2  <= gnt_sel ? bus.req1_b  : bus.req0_b;
                alu_opcode <= gnt_sel ? bus.req1_op : bus.req0_op;
            end
            if (state == EXEC) begin
                bus.rsp_result <= alu_result;
                bus.rsp_zero   <= alu_zero;
                // Carry is only meaningful for ADD (opcode 0).
                bus.rsp_carry  <= alu_carry && (alu_opcode == '0);
            end
            if (complete) begin
                prio <= ~owner;
                if (owner) done1_cnt <= done1_cnt + CNT_W'(1);
                else       done0_cnt <= done0_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational 16-bit ALU between two requesters using valid/ready handshakes. Requests are granted round-robin, operands and opcode are registered onto the ALU ports, and the result and flags are captured. The result is then returned on the owning requester's response channel. Sits between the two issuing units and the ALU instance; it is the only driver of the ALU inputs.

## Interface
- WIDTH, 16, operand/result width
- OPW, 4, opcode width
- CNT_W, 8, width of per-requester completion counters

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OPW  ALU opcode
- rsp0_valid / rsp1_valid  out  1  response present
- rsp0_ready / rsp1_ready  in  1  response consumed
- rsp_result  out  WIDTH  shared response data (valid only with rspN_valid)
- rsp_zero, rsp_carry  out  1  shared response flags
- alu_num_1, alu_num_2  out  WIDTH  registered ALU operands
- alu_opcode  out  OPW  registered ALU opcode
- alu_result  in  WIDTH  ALU result (combinational from alu_* outputs)
- alu_zero, alu_carry  in  1  ALU flags
- done0_cnt, done1_cnt  out  CNT_W  completed transactions per requester

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational.
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by the priority pointer `prio` is granted (0 = req0, 1 = req1).
  - reqN_ready = 1 only for the granted requester; the other ready is 0.
  - On valid&&ready: load alu_num_1/alu_num_2/alu_opcode from that requester, record `owner`, go to EXEC.
- EXEC (exactly one cycle):
  - Capture alu_result → rsp_result and alu_zero → rsp_zero.
  - rsp_carry = alu_carry when alu_opcode == 4'b0000; otherwise 0. The ALU carry is meaningful only for ADD and is sanitised here.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rsp valid is 0.
  - Hold rsp_* stable until rsp<owner>_ready.
  - On the handshake: go to IDLE, set prio = ~owner, increment done<owner>_cnt.
- Both reqN_ready are 0 in EXEC and RESP.
- Requesters must hold operands stable only while valid && !ready. Dropping valid in IDLE before grant is legal.
- Opcodes 8–15 are forwarded unchanged. The ALU returns 0, so the response is result 0, zero 1, carry 0.
- alu_* outputs keep their last value outside EXEC; they are never driven from unregistered request inputs.
- Counters wrap modulo 2^CNT_W (255 → 0).
- prio changes only on response completion, never on grant.

## Timing
- Reset (async assert, sync deassert at the flops):
  - State IDLE, prio = 0, owner = 0.
  - All rsp valids 0, rsp_result 0, rsp_zero 0, rsp_carry 0.
  - alu_num_1/alu_num_2 0, alu_opcode 0, done counters 0.
  - reqN_ready follows IDLE grant logic immediately after reset.
- Latency: accept edge T. EXEC during cycle T+1. rsp valid high from T+2.
- Minimum turnaround: 3 cycles per transaction when rsp_ready is held high. The next accept can occur at edge T+3, in IDLE.
- rsp_ready may be high before rsp_valid rises; completion then happens at the first edge with rsp_valid=1.
- Reset mid-operation (EXEC or RESP) abandons the transaction: no response, no counter increment, prio returns to 0.
- Both requesters continuously valid → grants alternate req0, req1, req0, …

## Test plan
- Reset then single ADD on req0 (a=16'hFFFF, b=16'h0001, op=0) → req0_ready at T, rsp0_valid at T+2, result 16'h0000, zero 1, carry 1, done0_cnt 1.
- Both valid continuously:
  - req0 AND (16'h0F0F & 16'h00FF) and req1 OR (16'h1200 | 16'h0034), rsp readies high.
  - Required: first grant req0 → result 16'h000F, carry 0; then req1 → result 16'h1234.
  - Grants alternate over 6 transactions; done0_cnt = done1_cnt = 3.
- Response backpressure: rsp1_ready low for 5 cycles after rsp1_valid → rsp_result/flags stable, both req readies 0, no new grant; release → IDLE next cycle.
- Carry sanitising and illegal opcode:
  - SUB 16'h0001−16'h0002 immediately after an ADD that carried → result 16'hFFFF, carry 0.
  - op=4'b1010 → result 0, zero 1, carry 0.
- Assert rst_n low while in RESP → all outputs to reset values asynchronously, no completion counted. After release, req1 alone valid → granted; response correct.
- 256 req0 transactions → done0_cnt wraps to 0; done1_cnt unchanged.
